// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Operation encoding follows funct3; FSM states and op helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  function automatic logic md_op_is_div(md_op_t op);
    return op[2];
  endfunction

  function automatic logic md_op_is_rem(md_op_t op);
    return op[2] & op[1];
  endfunction

  // rs1 is signed for MULH, MULHSU, DIV, REM
  function automatic logic md_signed_a(md_op_t op);
    return (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV)  || (op == MD_REM);
  endfunction

  // rs2 is signed for MULH, DIV, REM
  function automatic logic md_signed_b(md_op_t op);
    return (op == MD_MULH) || (op == MD_DIV) ||
           (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negator.
// Ports: neg selects negation, din operand, dout result.
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div unit, fixed WIDTH+2 cycle latency.
// Ports: clk, rst, start, op, SrcA, ALUop2, kill -> busy, done, result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] ALUop2,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  md_state_t        state;
  md_state_t        state_n;
  logic [CW-1:0]    cnt;
  md_op_t           op_q;
  logic             neg_a;
  logic             neg_b;
  logic             b_zero;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;

  logic             accept;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  logic             fix_neg;
  logic [2*WIDTH-1:0] fix_in;
  logic [2*WIDTH-1:0] fix_out;
  logic [WIDTH-1:0] fix_val;
  logic             sel_mul_lo;
  logic             sel_mul_hi;
  logic             sel_rem;
  logic             sel_quo;

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  // start only counts in IDLE/DONE; kill in that cycle suppresses it
  assign accept = start && !kill &&
                  ((state == IDLE) || (state == DONE));

  assign sa = md_signed_a(op) & SrcA[WIDTH-1];
  assign sb = md_signed_b(op) & ALUop2[WIDTH-1];

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (
    .neg  (sa),
    .din  (SrcA),
    .dout (a_mag)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (
    .neg  (sb),
    .din  (ALUop2),
    .dout (b_mag)
  );

  // acc = {hi, lo}: multiply keeps partial product in hi and
  // shifts the multiplier out of lo; divide keeps the partial
  // remainder in hi and shifts quotient bits into lo.
  assign hi = acc[2*WIDTH-1:WIDTH];
  assign lo = acc[WIDTH-1:0];

  assign mul_sum  = {1'b0, hi} +
                    {1'b0, (lo[0] ? mcand : '0)};
  assign mul_next = {mul_sum, lo[WIDTH-1:1]};

  assign shifted  = {hi, lo[WIDTH-1]};
  assign diff     = shifted - {1'b0, mcand};
  assign div_next = diff[WIDTH] ?
    {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0} :
    {diff[WIDTH-1:0],    lo[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = CALC;
      CALC: begin
        if (kill)
          state_n = IDLE;
        else if (cnt == CW'(WIDTH-1))
          state_n = FIX;
      end
      FIX:  state_n = kill ? IDLE : DONE;
      DONE: state_n = accept ? CALC : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // remainder sign follows the dividend; others use the xor
  assign fix_neg = md_op_is_rem(op_q) ? neg_a
                                      : (neg_a ^ neg_b);

  assign fix_in = !md_op_is_div(op_q) ? acc :
                  md_op_is_rem(op_q)  ? {{WIDTH{1'b0}}, hi} :
                                        {{WIDTH{1'b0}}, lo};

  muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_fix (
    .neg  (fix_neg),
    .din  (fix_in),
    .dout (fix_out)
  );

  assign sel_mul_lo = (op_q == MD_MUL);
  assign sel_mul_hi = !md_op_is_div(op_q) && !sel_mul_lo;
  assign sel_rem    = md_op_is_rem(op_q);
  assign sel_quo    = md_op_is_div(op_q) && !sel_rem;

  // Overflow (min / -1) falls out of the unsigned divide naturally.
  // Divide by zero yields an all-ones raw quotient, which the sign
  // fix would corrupt, so it is forced here; the remainder already
  // re-signs back to the original dividend.
  always_comb begin
    fix_val = '0;
    unique case (1'b1)
      sel_mul_lo: fix_val = fix_out[WIDTH-1:0];
      sel_mul_hi: fix_val = fix_out[2*WIDTH-1:WIDTH];
      sel_rem:    fix_val = fix_out[WIDTH-1:0];
      sel_quo:    fix_val = b_zero ? '1 : fix_out[WIDTH-1:0];
      default:    fix_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= MD_MUL;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        op_q   <= op;
        neg_a  <= sa;
        neg_b  <= sb;
        b_zero <= (ALUop2 == '0);
        mcand  <= b_mag;
        acc    <= {{WIDTH{1'b0}}, a_mag};
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
        acc <= md_op_is_div(op_q) ? div_next : mul_next;
      end
      if ((state == FIX) && !kill)
        result <= fix_val;
    end
  end

endmodule
